// File: rtl/iir_pkg.sv
// iir_pkg: shared defaults, parameter limits and a clog2 helper for the decimating buffer
package iir_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DECIM_MAX = 64;
  localparam int DEPTH_MAX = 64;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/iir_sync_fifo.sv
// iir_sync_fifo: first-word-fall-through synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module iir_sync_fifo
  import iir_pkg::*;
#(
  parameter int W = DATA_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = level == '0;
    full = level == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/iir_decim_buffer.sv
// iir_decim_buffer: decimates IIR output by DECIM into a FWFT FIFO with sticky overflow.
// Define IIR_DECIM_AVG_EN to push the window average instead of the last window sample.
module iir_decim_buffer
  import iir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      out_ready,
  input  logic                      ovf_clr,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [clog2(DEPTH):0]     level,
  output logic                      overflow
);
  localparam int PW = clog2(DECIM);
  logic [PW-1:0] phase;
  logic push, pop, full, empty, drop;
  logic [DATA_W-1:0] sample;
`ifdef IIR_DECIM_AVG_EN
  localparam int SW = DATA_W + PW;
  logic signed [SW-1:0] acc, sum;
  always_comb begin
    sum = (phase == '0 ? SW'(0) : acc) + SW'(in_data);
    sample = DATA_W'(sum >>> PW);
  end
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (in_valid) acc <= sum;
  end
`else
  assign sample = in_data;
`endif
  always_comb begin
    push = in_valid && phase == PW'(DECIM - 1);
    pop = out_valid && out_ready;
    drop = push && full && !pop;
    out_valid = !empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) phase <= phase + 1'b1;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  end
  iir_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(sample),
    .rdata(out_data),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule

// File: doc/iir_decim_buffer.md
IIR_DECIM_BUFFER -- requirements
Module: iir_decim_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed sample width of the IIR output y.
REQ-002 SHALL have parameter DECIM, default 4, meaning decimation factor, power of two, 2..64.
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO entries, power of two, 2..64.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  meaning synchronous active-high reset.
REQ-006 SHALL have port in_valid  in  1  meaning in_data carries a filter output sample this cycle.
REQ-007 SHALL have port in_data  in  DATA_W  meaning signed IIR output y.
REQ-008 SHALL have port out_ready  in  1  meaning consumer accepts out_data this cycle.
REQ-009 SHALL have port ovf_clr  in  1  meaning clears sticky overflow.
REQ-010 SHALL have port out_valid  out  1  meaning FIFO non-empty.
REQ-011 SHALL have port out_data  out  DATA_W  meaning FIFO head sample, first-word-fall-through.
REQ-012 SHALL have port level  out  log2(DEPTH)+1  meaning current FIFO occupancy.
REQ-013 SHALL have port overflow  out  1  meaning sticky flag: a decimated sample was dropped.

Function
REQ-014 SHALL keep phase counter 0..DECIM-1, incremented only on in_valid, wrapping DECIM-1 -> 0.
REQ-015 SHALL emit one decimated sample on the cycle in_valid=1 with phase=DECIM-1 ("push").
REQ-016 SHALL, without averaging, use in_data of the push cycle as the decimated sample.
REQ-017 SHALL make a pushed sample visible on out_data/out_valid the cycle after the push edge (latency 1) when FIFO was empty.
REQ-018 SHALL pop head when out_valid=1 and out_ready=1; out_ready with out_valid=0 is ignored.
REQ-019 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on push with level=DEPTH and no pop, drop the sample, set overflow, leave FIFO unchanged.
REQ-021 SHALL, on push and pop in the same cycle while full, accept the push (level stays DEPTH, no overflow).
REQ-022 SHALL, on push and pop in the same cycle at any level, leave level unchanged and preserve order.
REQ-023 SHALL keep overflow set until ovf_clr or rst; a drop coinciding with ovf_clr leaves overflow=1.
REQ-024 SHALL wrap read/write pointers modulo DEPTH without gaps.

Reset
REQ-025 SHALL on rst=1 at a clock edge set phase=0, level=0, out_valid=0, overflow=0, out_data=0, accumulator=0.
REQ-026 SHALL let reset mid-window discard the partial window and all FIFO contents; in_valid during rst ignored.

Configuration
REQ-027 SHALL with macro IIR_DECIM_AVG_EN defined push the average of the DECIM window samples: signed sum in DATA_W+log2(DECIM) bits, arithmetic right shift by log2(DECIM) (rounds toward minus infinity), accumulator reloaded on phase 0.
REQ-028 SHALL without IIR_DECIM_AVG_EN instantiate no accumulator and push the last window sample (REQ-016).

Structure
REQ-029 SHALL place DATA_W default, max DECIM/DEPTH limits and a clog2 helper in shared package iir_pkg.
REQ-030 SHALL implement storage as sub-module iir_sync_fifo (FWFT, push/pop/full/empty/level); decimation and overflow logic in the top.

Verification
REQ-031 SHALL test: no avg, DECIM=4, in_valid every cycle with in_data 1,2,3,...,16, out_ready=1 -> outputs 4,8,12,16, each one cycle after push.
REQ-032 SHALL test: IIR_DECIM_AVG_EN, window -3,-2,-2,-2 -> out_data -3 (sum -9 >> 2); window 16'h7FFF x4 -> 16'h7FFF.
REQ-033 SHALL test: out_ready=0, 9 pushes with DEPTH=8 -> level=8, overflow=1, first 8 samples read back in order after out_ready=1.
REQ-034 SHALL test: full FIFO, push and pop same cycle -> level stays 8, overflow stays 0, new sample appears last.
REQ-035 SHALL test: rst after 2 of 4 window samples with 3 samples queued -> out_valid=0, level=0 next cycle; next output equals sample 4 of fresh window.
REQ-036 SHALL test: gapped in_valid (1 of 3 cycles) -> push only on 4th valid sample; ovf_clr with simultaneous drop -> overflow stays 1.
